// File: rtl/mips_runctl_pkg.sv
// mips_runctl_pkg: state encoding and shared constants for the MIPS run controller.
package mips_runctl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN, DONE} state_t;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_TIMEOUT_CYCLES = 30;
    localparam int DEF_HALT_STABLE = 2;
endpackage

// File: rtl/mips_halt_detect.sv
// mips_halt_detect: flags a jump-to-self once core_pc has held still for HALT_STABLE cycles.
module mips_halt_detect
    import mips_runctl_pkg::*;
#(
    parameter int HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] pc,
    output logic        halt
);
    localparam int SW = $clog2(HALT_STABLE + 1);

    logic [31:0]   prev_pc;
    logic          primed;
    logic [SW-1:0] stable;
    logic          same;

    // primed keeps the first enabled cycle from comparing against a stale PC
    assign same = enable && primed && (pc == prev_pc);
    // fires in the cycle the count reaches HALT_STABLE so the run ends on that edge
    assign halt = same && (stable == SW'(HALT_STABLE - 1));

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            primed  <= 1'b0;
            prev_pc <= '0;
            stable  <= '0;
        end else begin
            primed  <= 1'b1;
            prev_pc <= pc;
            stable  <= same ? stable + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/mips_run_controller.sv
// mips_run_controller: loads imem, pads it with NOPs, then resets, runs and stops the core.
// Define MIPS_RUNCTL_SIGNATURE_EN to build the rolling pc_signature; otherwise it is tied to 0.
module mips_run_controller
    import mips_runctl_pkg::*;
#(
    parameter int IMEM_DEPTH     = 1024,
    parameter int ADDR_W         = $clog2(IMEM_DEPTH),
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HALT_STABLE    = DEF_HALT_STABLE,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    input  logic [31:0]       core_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [31:0]       pc_signature
);
    localparam int HW = $clog2(RESET_CYCLES + 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [HW-1:0]     hold_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              xfer;
    logic              last_addr;
    logic              halt;
    logic              restart;

    assign load_ready = state == LOAD;
    assign xfer       = load_ready && load_valid;
    assign last_addr  = &ptr;
    assign imem_we    = xfer || state == FILL;
    assign imem_addr  = ptr;
    assign imem_wdata = xfer ? load_data : NOP_WORD;
    assign core_reset = reset || state != RUN;
    assign busy       = state != IDLE && state != DONE;
    assign restart    = start && (state == IDLE || state == DONE);
    assign cnt_next   = &cycle_count ? cycle_count : cycle_count + 1'b1;

    mips_halt_detect #(.HALT_STABLE(HALT_STABLE)) u_halt (
        .clk(clk),
        .reset(reset),
        .enable(state == RUN),
        .pc(core_pc),
        .halt(halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (restart) begin
                    state       <= LOAD;
                    ptr         <= '0;
                    cycle_count <= '0;
                    done        <= 1'b0;
                    timeout     <= 1'b0;
                    load_err    <= 1'b0;
                end
                LOAD: if (xfer) begin
                    ptr <= ptr + 1'b1;
                    if (load_last) state <= last_addr ? HOLD : FILL;
                    else if (last_addr) begin
                        load_err <= 1'b1;
                        state    <= HOLD;
                    end
                end
                FILL: begin
                    ptr <= ptr + 1'b1;
                    if (last_addr) state <= HOLD;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                        hold_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_next;
                    // halt has priority over a coincident timeout
                    if (halt || cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= !halt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIPS_RUNCTL_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (reset || restart) pc_signature <= '0;
        else if (state == RUN) pc_signature <= {pc_signature[30:0], pc_signature[31]} ^ core_pc;
    end
`else
    assign pc_signature = 32'h0;
`endif
endmodule
